usb_sie_line_monitor: RTL
=========================

// Module: usb_sie_line_monitor
// PURPOSE
//   Host-side USB line-state monitor in the serial interface engine; successor to the fixed-threshold connect detector.
//   Qualifies device attach, detects full- or low-speed attach, qualifies disconnect on a long SE0, and detects remote-wake
//   resume (K) while suspended. All thresholds are parametrised and counted in accepted line samples.
//   Input comes from the wire receiver's sample strobe. Outputs feed the SIE controller and the status registers.
// PARAMETERS
//   CNT_W              16   width of the shared sample counter
//   CONNECT_SAMPLES    121  consecutive identical J samples needed to declare a connect
//   DISCONNECT_SAMPLES 121  consecutive SE0 samples while connected needed to declare a disconnect
//   RESUME_SAMPLES     8    consecutive K samples needed to declare resume when resume_det_en=1
//   Constraint: every threshold is >=2 and <2**CNT_W. The bench checks this with an elaboration-time assertion.
// PORTS
//   clk            in   1  system clock
//   rst            in   1  synchronous reset, active high
//   line_state     in   2  {dp,dm} sample: 00 SE0, 10 FS-J, 01 LS-J, 11 SE1
//   line_state_we  in   1  line_state is valid this cycle; nothing advances when this is low
//   resume_det_en  in   1  bus is suspended; enables K-state resume detection
//   connect_state  out  2  0 disconnected, 1 low-speed, 2 full-speed (3 is never driven)
//   conn_event     out  1  1-cycle pulse on every change of connect_state
//   resume_det     out  1  1-cycle pulse when a resume is qualified
//   se0_active     out  1  high while connected and the last accepted sample was SE0
// BEHAVIOUR
//   One clock and synchronous reset only. Every output is registered. A sample is accepted at a posedge with line_state_we=1.
//   An output effect of an accepted sample is visible in the cycle after that edge (latency 1).
//   Reset: state=DISC, cnt=0, spd=0, connect_state=0, conn_event=0, resume_det=0, se0_active=0.
//     rst has priority over line_state_we. Reset mid-qualification discards the partial count.
//   J for the current speed: spd=FS gives J=10, K=01. spd=LS gives J=01, K=10. spd is latched on entry to CONN_QUAL.
//   FSM transitions, on accepted samples only:
//     DISC: FS-J or LS-J -> CONN_QUAL, spd=that speed, cnt=1. SE0 or SE1 -> stay.
//     CONN_QUAL:
//       - J matching spd: cnt+1. If the new cnt equals CONNECT_SAMPLES -> CONNECTED, connect_state=spd, conn_event=1, cnt=0.
//       - The other J: restart qualification with that speed, cnt=1.
//       - SE0 or SE1 -> DISC, cnt=0.
//     CONNECTED:
//       - SE0 -> SE0_QUAL, cnt=1, se0_active=1.
//       - K with resume_det_en=1 -> RES_QUAL, cnt=1.
//       - Otherwise stay, cnt=0. This covers J, K with resume_det_en=0, and SE1 (SE1 is ignored).
//     SE0_QUAL:
//       - SE0: cnt+1. If the new cnt equals DISCONNECT_SAMPLES -> DISC, connect_state=0, conn_event=1, se0_active=0, cnt=0.
//       - Any non-SE0 -> CONNECTED, cnt=0, se0_active=0. A short SE0 is an EOP or keep-alive.
//     RES_QUAL:
//       - K: cnt+1. If the new cnt equals RESUME_SAMPLES -> CONNECTED, resume_det=1, cnt=0.
//       - SE0 -> SE0_QUAL, cnt=1.
//       - J or SE1 -> CONNECTED, cnt=0.
//       - resume_det_en falling while in RES_QUAL -> CONNECTED, cnt=0. This applies even with no sample that cycle.
//   Counter: CNT_W bits and saturating. It can never wrap because it resets on reaching any threshold.
//   The threshold compare is on the incremented value, so exactly N samples qualify (not N+1).
//   conn_event and resume_det are high for one cycle only and are never both high in the same cycle.
//   With line_state_we low, state, cnt and levels hold, and the pulses drop to 0.
//   A speed change while connected requires a disconnect first. Dp/dm swaps while CONNECTED are treated as K, not reconnect.
// STRUCTURE
//   usb_sie_pkg holds:
//     - line-state constants LS_SE0, LS_FSJ, LS_LSJ, LS_SE1
//     - connect encodings CONN_NONE, CONN_LS, CONN_FS
//     - FSM state localparams DISC, CONN_QUAL, CONNECTED, SE0_QUAL, RES_QUAL (3 bits)
//   The design is a single module: a next-state always block plus a registered block.
//   No sub-module is needed. The one counter is shared by all states.
// TESTING
//   1) rst, then 121 x FS-J (10) with we=1 -> connect_state 0->2 exactly after sample 121, conn_event one pulse.
//   2) 120 x LS-J, 1 x SE0, 121 x LS-J -> no connect after the first burst, then connect_state=1 after the full second burst.
//   3) Connected FS, 5 x SE0, then J -> se0_active high for 5 cycles, connect_state stays 2, no conn_event.
//   4) Connected FS, 121 x SE0 -> connect_state=0 and conn_event after the 121st; se0_active drops in the same cycle.
//   5) Connected FS, resume_det_en=1, 8 x K (01) -> resume_det one pulse.
//      Repeat with resume_det_en=0 -> no pulse, state CONNECTED.
//   6) Mid-CONN_QUAL (60 samples) assert rst for 1 cycle, hold we=0 gaps of 3 cycles between samples
//      -> count restarts, connect needs a fresh 121 samples, and gaps do not advance cnt.

Source files
------------

// File: rtl/usb_sie_pkg.sv
// Shared encodings for the USB serial interface engine: line states, connect
// status values and the line-monitor FSM state codes.
package usb_sie_pkg;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_FSJ = 2'b10;
  localparam logic [1:0] LS_LSJ = 2'b01;
  localparam logic [1:0] LS_SE1 = 2'b11;

  localparam logic [1:0] CONN_NONE = 2'd0;
  localparam logic [1:0] CONN_LS   = 2'd1;
  localparam logic [1:0] CONN_FS   = 2'd2;

  localparam logic [2:0] DISC      = 3'd0;
  localparam logic [2:0] CONN_QUAL = 3'd1;
  localparam logic [2:0] CONNECTED = 3'd2;
  localparam logic [2:0] SE0_QUAL  = 3'd3;
  localparam logic [2:0] RES_QUAL  = 3'd4;

endpackage

// File: rtl/usb_sie_line_monitor.sv
// Host-side USB line-state monitor: qualifies attach speed, long-SE0 disconnect
// and remote-wake resume, all counted in accepted line samples.
import usb_sie_pkg::*;

module usb_sie_line_monitor #(
  parameter int CNT_W              = 16,
  parameter int CONNECT_SAMPLES    = 121,
  parameter int DISCONNECT_SAMPLES = 121,
  parameter int RESUME_SAMPLES     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] line_state,
  input  logic       line_state_we,
  input  logic       resume_det_en,
  output logic [1:0] connect_state,
  output logic       conn_event,
  output logic       resume_det,
  output logic       se0_active
);

  localparam logic [CNT_W-1:0] CONN_TH = CNT_W'(CONNECT_SAMPLES);
  localparam logic [CNT_W-1:0] DISC_TH = CNT_W'(DISCONNECT_SAMPLES);
  localparam logic [CNT_W-1:0] RES_TH  = CNT_W'(RESUME_SAMPLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [2:0]       state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext, cntInc;
  logic             spd, spdNext;
  logic [1:0]       connStateNext;
  logic             connEventNext, resumeDetNext, se0Next;
  logic [1:0]       curJ, curK;

  // spd=1 is full speed; J and K swap polarity with the attached speed.
  assign curJ   = spd ? LS_FSJ : LS_LSJ;
  assign curK   = spd ? LS_LSJ : LS_FSJ;
  assign cntInc = (cnt == '1) ? cnt : cnt + ONE;

  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    spdNext       = spd;
    connStateNext = connect_state;
    connEventNext = 1'b0;
    resumeDetNext = 1'b0;
    se0Next       = se0_active;
    // Leaving suspend aborts resume qualification even without a sample.
    if (state == RES_QUAL && !resume_det_en) begin
      stateNext = CONNECTED;
      cntNext   = '0;
    end else if (line_state_we) begin
      case (state)
        DISC: begin
          if (line_state == LS_FSJ || line_state == LS_LSJ) begin
            stateNext = CONN_QUAL;
            spdNext   = (line_state == LS_FSJ);
            cntNext   = ONE;
          end
        end
        CONN_QUAL: begin
          if (line_state == curJ) begin
            cntNext = cntInc;
            if (cntInc == CONN_TH) begin
              stateNext     = CONNECTED;
              connStateNext = spd ? CONN_FS : CONN_LS;
              connEventNext = 1'b1;
              cntNext       = '0;
            end
          end else if (line_state == curK) begin
            spdNext = ~spd;
            cntNext = ONE;
          end else begin
            stateNext = DISC;
            cntNext   = '0;
          end
        end
        CONNECTED: begin
          if (line_state == LS_SE0) begin
            stateNext = SE0_QUAL;
            cntNext   = ONE;
            se0Next   = 1'b1;
          end else if (line_state == curK && resume_det_en) begin
            stateNext = RES_QUAL;
            cntNext   = ONE;
          end else begin
            cntNext = '0;
          end
        end
        SE0_QUAL: begin
          if (line_state == LS_SE0) begin
            cntNext = cntInc;
            if (cntInc == DISC_TH) begin
              stateNext     = DISC;
              connStateNext = CONN_NONE;
              connEventNext = 1'b1;
              se0Next       = 1'b0;
              cntNext       = '0;
            end
          end else begin
            stateNext = CONNECTED;
            cntNext   = '0;
            se0Next   = 1'b0;
          end
        end
        RES_QUAL: begin
          if (line_state == curK) begin
            cntNext = cntInc;
            if (cntInc == RES_TH) begin
              stateNext     = CONNECTED;
              resumeDetNext = 1'b1;
              cntNext       = '0;
            end
          end else if (line_state == LS_SE0) begin
            stateNext = SE0_QUAL;
            cntNext   = ONE;
            se0Next   = 1'b1;
          end else begin
            stateNext = CONNECTED;
            cntNext   = '0;
          end
        end
        default: begin
          stateNext     = DISC;
          cntNext       = '0;
          connStateNext = CONN_NONE;
          se0Next       = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= DISC;
      cnt           <= '0;
      spd           <= 1'b0;
      connect_state <= CONN_NONE;
      conn_event    <= 1'b0;
      resume_det    <= 1'b0;
      se0_active    <= 1'b0;
    end else begin
      state         <= stateNext;
      cnt           <= cntNext;
      spd           <= spdNext;
      connect_state <= connStateNext;
      conn_event    <= connEventNext;
      resume_det    <= resumeDetNext;
      se0_active    <= se0Next;
    end
  end

endmodule
